alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_arbiter_if.sv | 41 ++++
 rtl/alu_arbiter_alu32.sv | 28 ++
 rtl/alu_arbiter.sv | 85 ++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: control codes, control type and the arbiter's result-slot states.
package alu_pkg;

  typedef logic [3:0] ctl_t;

  localparam ctl_t ALU_AND = 4'd0;
  localparam ctl_t ALU_OR  = 4'd1;
  localparam ctl_t ALU_ADD = 4'd2;
  localparam ctl_t ALU_SUB = 4'd6;
  localparam ctl_t ALU_SLT = 4'd7;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic ctl_supported(input ctl_t c);
    return (c == ALU_AND) || (c == ALU_OR) || (c == ALU_ADD) ||
           (c == ALU_SUB) || (c == ALU_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle for alu_arbiter; master = requesters and consumer, slave = arbiter.
interface alu_arbiter_if;
  import alu_pkg::*;

  logic        req0_valid;
  logic        req0_ready;
  ctl_t        req0_ctl;
  logic [31:0] req0_a;
  logic [31:0] req0_b;

  logic        req1_valid;
  logic        req1_ready;
  ctl_t        req1_ctl;
  logic [31:0] req1_a;
  logic [31:0] req1_b;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_zero;
  logic        rsp_err;
  logic [15:0] op_count;

  modport master (
    output req0_valid, req0_ctl, req0_a, req0_b,
    output req1_valid, req1_ctl, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, op_count
  );

  modport slave (
    input  req0_valid, req0_ctl, req0_a, req0_b,
    input  req1_valid, req1_ctl, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_zero, rsp_err, op_count
  );

endinterface

// File: rtl/alu_arbiter_alu32.sv
// 32-bit combinational ALU (AND/OR/ADD/SUB/SLT); zero latency, no flow control.
// Unsupported codes yield result 0 with err set and zero cleared.
module alu32
  import alu_pkg::*;
(
  input  ctl_t        ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero,
  output logic        err
);

  always_comb begin
    result = '0;
    err    = !ctl_supported(ctl);
    case (ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_SLT: result = {31'd0, ($signed(a) < $signed(b))};
      default: result = '0;
    endcase
    zero = !err && (result == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter sharing one ALU; result registered (latency 1), one result slot.
// Readies drop while the held result is stalled by rsp_ready; drain+accept in one cycle keeps 1 op/cycle.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter bit FAIR = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  alu_arbiter_if.slave  bus
);

  state_t      state;
  logic        ptr;
  logic        rsp_valid_q;
  logic        rsp_id_q;
  logic [31:0] rsp_data_q;
  logic        rsp_zero_q;
  logic        rsp_err_q;
  logic [15:0] op_count_q;

  logic        slot_free;
  logic        gnt_id;
  logic        accept;
  ctl_t        sel_ctl;
  logic [31:0] sel_a;
  logic [31:0] sel_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        alu_err;

  // Requester 1 wins only when alone, or when the round-robin pointer favours it.
  assign gnt_id    = bus.req1_valid && (!bus.req0_valid || (FAIR && ptr));
  assign slot_free = (state == IDLE) || (rsp_valid_q && bus.rsp_ready);
  assign accept    = !reset && slot_free && (bus.req0_valid || bus.req1_valid);

  assign bus.req0_ready = accept && !gnt_id;
  assign bus.req1_ready = accept && gnt_id;

  assign sel_ctl = gnt_id ? bus.req1_ctl : bus.req0_ctl;
  assign sel_a   = gnt_id ? bus.req1_a   : bus.req0_a;
  assign sel_b   = gnt_id ? bus.req1_b   : bus.req0_b;

  alu32 u_alu (
    .ctl    (sel_ctl),
    .a      (sel_a),
    .b      (sel_b),
    .result (alu_res),
    .zero   (alu_zero),
    .err    (alu_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
    end else if (accept) begin
      state       <= HOLD;
      ptr         <= !gnt_id;
      rsp_valid_q <= 1'b1;
      rsp_id_q    <= gnt_id;
      rsp_data_q  <= alu_res;
      rsp_zero_q  <= alu_zero;
      rsp_err_q   <= alu_err;
      op_count_q  <= op_count_q + 16'd1;
    end else if (rsp_valid_q && bus.rsp_ready) begin
      state       <= IDLE;
      rsp_valid_q <= 1'b0;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_zero  = rsp_zero_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.op_count  = op_count_q;

endmodule
